// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : fetch_sequencer_if
// Brief  : Instruction-memory read port plus datapath issue handshake and flags.
// Rev    : 1.0
// ============================================================================
interface fetch_sequencer_if;
    logic [11:0] instr_addr;
    logic [18:0] instruction;
    logic [18:0] instr_out;
    logic        instr_valid;
    logic        instr_ready;
    logic        flag_z;
    logic        flag_c;

    modport master (
        output instr_addr,
        output instr_out,
        output instr_valid,
        input  instruction,
        input  instr_ready,
        input  flag_z,
        input  flag_c
    );

    modport slave (
        input  instr_addr,
        input  instr_out,
        input  instr_valid,
        output instruction,
        output instr_ready,
        output flag_z,
        output flag_c
    );
endinterface
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module : fetch_sequencer
// Brief  : PC owner for the 19-bit core; resolves control flow, forwards datapath
//          words. Define FETCH_RSTACK_EN for a deep return stack (else one link reg).
// Rev    : 1.0
// ============================================================================
module fetch_sequencer #(
    parameter logic [11:0] START_ADDR   = 12'd1,
    parameter int          RSTACK_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    fetch_sequencer_if.master bus,
    output logic             halted,
    output logic             stack_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t      state;
    logic [11:0] pc;
    logic [18:0] instr;
    logic [11:0] pc_inc;
    logic [11:0] branch_target;
    logic        is_branch, is_jmp, is_jsb, is_ret, is_halt, is_dp;
    logic        cond_met;
    logic        in_run;
    logic        push, pop, stk_clear;
    logic        stk_full, stk_empty;
    logic [11:0] stk_top;

    assign instr         = bus.instruction;
    assign pc_inc        = pc + 12'd1;
    assign branch_target = pc_inc + {{4{instr[7]}}, instr[7:0]};

    assign is_branch = (instr[18:16] == 3'b101);
    assign is_jmp    = (instr[18:14] == 5'b11100);
    assign is_jsb    = (instr[18:14] == 5'b11101);
    assign is_ret    = (instr[18:13] == 6'b111100);
    assign is_halt   = (instr == 19'h00000);
    assign is_dp     = !(is_branch || is_jmp || is_jsb || is_ret || is_halt);

    always_comb begin
        cond_met = 1'b0;
        case (instr[15:14])
            2'b00:   cond_met = bus.flag_z;
            2'b01:   cond_met = !bus.flag_z;
            2'b10:   cond_met = bus.flag_c;
            default: cond_met = !bus.flag_c;
        endcase
    end

    assign in_run    = (state == S_RUN);
    assign push      = in_run && is_jsb && !stk_full;
    assign pop       = in_run && is_ret && !stk_empty;
    assign stk_clear = (state == S_HALT) && start;

    // Forward path is purely combinational so a datapath word issues the cycle PC reaches it.
    assign bus.instr_addr  = pc;
    assign bus.instr_out   = instr;
    assign bus.instr_valid = in_run && is_dp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            pc        <= START_ADDR;
            halted    <= 1'b0;
            stack_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pc    <= START_ADDR;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (is_halt) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else if (is_branch) begin
                        pc <= cond_met ? branch_target : pc_inc;
                    end else if (is_jmp) begin
                        pc <= instr[11:0];
                    end else if (is_jsb) begin
                        if (stk_full) begin
                            stack_err <= 1'b1;
                            state     <= S_HALT;
                            halted    <= 1'b1;
                        end else begin
                            pc <= instr[11:0];
                        end
                    end else if (is_ret) begin
                        if (stk_empty) begin
                            stack_err <= 1'b1;
                            state     <= S_HALT;
                            halted    <= 1'b1;
                        end else begin
                            pc <= stk_top;
                        end
                    end else if (bus.instr_ready) begin
                        pc <= pc_inc;
                    end
                end
                S_HALT: begin
                    if (start) begin
                        pc        <= START_ADDR;
                        stack_err <= 1'b0;
                        halted    <= 1'b0;
                        state     <= S_RUN;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    halted <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_RSTACK_EN
    localparam int SP_W = $clog2(RSTACK_DEPTH) + 1;

    logic [SP_W-1:0] sp;
    logic [SP_W-2:0] top_idx;
    logic [11:0]     stk_mem [RSTACK_DEPTH];

    assign top_idx   = sp[SP_W-2:0] - (SP_W-1)'(1);
    assign stk_full  = (sp == SP_W'(RSTACK_DEPTH));
    assign stk_empty = (sp == '0);
    assign stk_top   = stk_mem[top_idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp <= '0;
        end else if (stk_clear) begin
            sp <= '0;
        end else if (push) begin
            sp <= sp + SP_W'(1);
        end else if (pop) begin
            sp <= sp - SP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            stk_mem[sp[SP_W-2:0]] <= pc_inc;
        end
    end
`else
    logic        link_valid;
    logic [11:0] link_reg;

    // Depth has no effect with a single link register; folding it in keeps it referenced.
    assign stk_full  = link_valid && (RSTACK_DEPTH > 0);
    assign stk_empty = !link_valid;
    assign stk_top   = link_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            link_valid <= 1'b0;
            link_reg   <= 12'd0;
        end else if (stk_clear) begin
            link_valid <= 1'b0;
        end else if (push) begin
            link_valid <= 1'b1;
            link_reg   <= pc_inc;
        end else if (pop) begin
            link_valid <= 1'b0;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_fetch_sequencer
// Brief  : Directed scoreboard bench for fetch_sequencer.
// Rev    : 1.0
// ============================================================================
module tb_fetch_sequencer;

`ifdef FETCH_RSTACK_EN
    localparam int CAP = 8;
`else
    localparam int CAP = 1;
`endif
    localparam logic [18:0] RET_W  = {6'b111100, 13'b0};
    localparam logic [18:0] HALT_W = 19'h00000;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic start = 1'b0;
    logic halted;
    logic stack_err;

    fetch_sequencer_if bus ();
    logic [18:0] mem [4096];

    assign bus.instruction = mem[bus.instr_addr];

    fetch_sequencer #(
        .START_ADDR   (12'd1),
        .RSTACK_DEPTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bus       (bus),
        .halted    (halted),
        .stack_err (stack_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] v;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [18:0] br(input logic [1:0] c, input logic [7:0] o);
        return {3'b101, c, 6'b0, o};
    endfunction
    function automatic logic [18:0] jmp(input logic [11:0] a);
        return {5'b11100, 2'b0, a};
    endfunction
    function automatic logic [18:0] jsb(input logic [11:0] a);
        return {5'b11101, 2'b0, a};
    endfunction

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            0:       return {20'b0, bus.instr_addr};
            1:       return {31'b0, bus.instr_valid};
            2:       return {31'b0, halted};
            3:       return {31'b0, stack_err};
            default: return {13'b0, bus.instr_out};
        endcase
    endfunction

    task automatic expect_v(input string tag, input int sel, input logic [31:0] v);
        q.push_back('{tag, sel, v});
    endtask

    task automatic sample();
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            assert (observe(e.sel) === e.v)
            else begin
                errors++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, observe(e.sel), e.v);
            end
        end
    endtask

    task automatic step();
        #1;
        sample();
        @(negedge clk);
    endtask

    task automatic cyc(input string tag, input logic [11:0] a, input logic vld);
        expect_v({tag, "_addr"}, 0, {20'b0, a});
        expect_v({tag, "_valid"}, 1, {31'b0, vld});
        step();
    endtask

    task automatic status(input string tag, input logic h, input logic err);
        expect_v({tag, "_halted"}, 2, {31'b0, h});
        expect_v({tag, "_stack_err"}, 3, {31'b0, err});
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 19'h00001;
        mem[0]        = jmp(12'd40);
        mem[1]        = 19'h12345;
        mem[2]        = jmp(12'd5);
        mem[4]        = br(2'b00, 8'h06);
        mem[5]        = 19'h23456;
        mem[6]        = jmp(12'd4);
        mem[11]       = jmp(12'd4);
        mem[40]       = jsb(12'd45);
        mem[41]       = jmp(12'd11);
        mem[45]       = RET_W;
        mem[12'hFFF]  = 19'h0ABCD;
        for (int k = 0; k < 20; k++) mem[100 + k] = jsb(12'(101 + k));
        bus.instr_ready = 1'b0;
        bus.flag_z      = 1'b0;
        bus.flag_c      = 1'b0;

        @(negedge clk);
        @(negedge clk);
        status("reset", 1'b0, 1'b0);
        cyc("reset", 12'd1, 1'b0);
        rst = 1'b1;

        // Start from IDLE and issue the first datapath word.
        start = 1'b1; bus.instr_ready = 1'b1;
        cyc("idle", 12'd1, 1'b0);
        start = 1'b0;
        expect_v("issue1_out", 4, {13'b0, 19'h12345});
        cyc("issue1", 12'd1, 1'b1);
        cyc("jmp5", 12'd2, 1'b0);

        // Back-pressure: PC and valid hold while ready is low.
        bus.instr_ready = 1'b0;
        cyc("stall1", 12'd5, 1'b1);
        cyc("stall2", 12'd5, 1'b1);
        cyc("stall3", 12'd5, 1'b1);
        bus.instr_ready = 1'b1;
        cyc("accept", 12'd5, 1'b1);
        bus.flag_z = 1'b1;
        cyc("after_accept", 12'd6, 1'b0);

        cyc("br_taken", 12'd4, 1'b0);
        bus.flag_z = 1'b0;
        cyc("br_target", 12'd11, 1'b0);
        cyc("br_not_taken", 12'd4, 1'b0);
        mem[4] = br(2'b00, 8'hFA);
        bus.flag_z = 1'b1;
        cyc("br_fallthru", 12'd5, 1'b1);
        cyc("to_br_back", 12'd6, 1'b0);
        cyc("br_back", 12'd4, 1'b0);
        expect_v("wrap_out", 4, {13'b0, 19'h0ABCD});
        cyc("br_wrap", 12'hFFF, 1'b1);
        cyc("pc_wrap", 12'h000, 1'b0);

        // Subroutine call and return.
        cyc("jsb", 12'd40, 1'b0);
        cyc("ret", 12'd45, 1'b0);
        mem[11] = HALT_W;
        cyc("ret_dest", 12'd41, 1'b0);
        status("halt_word", 1'b0, 1'b0);
        cyc("halt_word", 12'd11, 1'b0);
        status("halted1", 1'b1, 1'b0);
        cyc("halted1", 12'd11, 1'b0);
        status("halted2", 1'b1, 1'b0);
        cyc("halted2", 12'd11, 1'b0);
        start = 1'b1;
        status("restart", 1'b1, 1'b0);
        cyc("restart", 12'd11, 1'b0);
        start = 1'b0;
        mem[2] = RET_W;
        status("resume", 1'b0, 1'b0);
        cyc("resume", 12'd1, 1'b1);

        // Return with nothing on the stack.
        status("ret_empty", 1'b0, 1'b0);
        cyc("ret_empty", 12'd2, 1'b0);
        status("underflow", 1'b1, 1'b1);
        step();
        start = 1'b1;
        status("underflow_hold", 1'b1, 1'b1);
        step();
        start = 1'b0;
        mem[2] = jsb(12'd100);
        status("clear_err", 1'b0, 1'b0);
        cyc("clear_err", 12'd1, 1'b1);

        // Nest calls one deeper than the stack holds.
        for (int i = 1; i <= CAP + 1; i++) begin
            status($sformatf("nest%0d", i), 1'b0, 1'b0);
            cyc($sformatf("nest%0d", i), (i == 1) ? 12'd2 : 12'(100 + i - 2), 1'b0);
        end
        status("overflow", 1'b1, 1'b1);
        cyc("overflow", 12'(100 + CAP - 1), 1'b0);

        // Asynchronous reset during a stalled handshake.
        start = 1'b1; bus.instr_ready = 1'b0;
        status("pre_reset", 1'b1, 1'b1);
        step();
        start = 1'b0;
        cyc("pending", 12'd1, 1'b1);
        #2 rst = 1'b0;
        #1;
        expect_v("async_rst_valid", 1, 32'd0);
        expect_v("async_rst_addr", 0, 32'd1);
        status("async_rst", 1'b0, 1'b0);
        sample();
        @(negedge clk);
        rst = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
# fetch_sequencer

Program sequencer sitting between the instruction memory and the datapath of the 19-bit core. Owns the 12-bit PC and drives the instruction memory's read address. Resolves all control-flow instructions (branch, jump, subroutine call/return) internally using the datapath's Z/C flags, and forwards only datapath instructions over a valid/ready handshake. Also provides a hardware return stack and halt/error status.

## Interface
- START_ADDR, 12'd1: PC value loaded on reset and on restart.
- RSTACK_DEPTH, 8: return-stack entries when FETCH_RSTACK_EN is defined (power of two, 2..16).
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  leave IDLE/HALT and begin fetching at START_ADDR
- instr_addr  out  12  instruction memory read address (= PC)
- instruction  in  19  instruction memory read data, combinational from instr_addr
- instr_out  out  19  instruction forwarded to datapath (= instruction)
- instr_valid  out  1  instr_out holds a datapath instruction
- instr_ready  in  1  datapath accepts instr_out this cycle
- flag_z, flag_c  in  1 each  datapath flags, already updated for every accepted instruction
- halted  out  1  sequencer is in HALT
- stack_err  out  1  sticky, return-stack overflow/underflow

## Operation
- Decode of instruction[18:0]:
  - [18:16]=101: BRANCH; cond [15:14]: 00 Z, 01 NZ, 10 C, 11 NC; offset [7:0] signed two's complement.
  - [18:14]=11100: JMP to [11:0].
  - [18:14]=11101: JSB; push PC+1, then jump to [11:0].
  - [18:13]=111100: RET; pop into PC.
  - 19'h00000: HALT.
  - All other words: datapath instruction.
- States:
  - IDLE (reset state): instr_valid=0. start -> RUN.
  - RUN
  - HALT: instr_valid=0, halted=1. start -> reload PC=START_ADDR, empty the stack, clear stack_err, go to RUN.
- RUN behaviour, one instruction evaluated per cycle:
  - Datapath instruction: instr_valid=1. On instr_valid&&instr_ready, PC<=PC+1. While ready=0, PC, instr_out and instr_valid hold.
  - BRANCH: instr_valid=0. If taken, PC<=PC+1+sext(offset); otherwise PC<=PC+1. Flags are sampled in this same cycle.
  - JMP: PC<=[11:0], instr_valid=0.
  - JSB: if the stack is full, set stack_err and go to HALT with PC unchanged. Otherwise push PC+1 and set PC<=[11:0].
  - RET: if the stack is empty, set stack_err and go to HALT. Otherwise PC<=popped value.
  - HALT word: go to HALT, PC unchanged, instr_valid=0.
- Arithmetic: all PC arithmetic is modulo 4096. PC+1 at 12'hFFF wraps to 12'h000. Branch targets wrap in both directions.
- start while in RUN is ignored.

## Timing
- Reset values:
  - state=IDLE, PC=START_ADDR, instr_addr=START_ADDR
  - instr_valid=0, halted=0, stack_err=0, stack pointer=0
  - instr_out follows instruction combinationally (content not meaningful while instr_valid=0)
- instr_addr is registered (PC). instr_out and instr_valid are combinational from PC, instruction and state; no registering on the forward path.
- Latency:
  - Datapath instruction: issues in the cycle PC points at it.
  - Control instruction: costs exactly 1 cycle with instr_valid=0; the next PC is visible on the following edge.
- Handshake: instr_valid never drops while instr_ready=0 in RUN (no reset in between). The datapath must not change flag_z/flag_c except on an accept edge.
- Asynchronous reset mid-handshake drops instr_valid immediately, and the pending instruction is lost.
- A transition to HALT takes effect on the clock edge; halted rises in the following cycle.

## Configuration
- FETCH_RSTACK_EN defined: the return stack is an RSTACK_DEPTH-entry LIFO with a pointer; nesting up to RSTACK_DEPTH calls is supported.
- FETCH_RSTACK_EN undefined: a single link register with a valid bit, giving one level of call.
  - A JSB while the link register is valid sets stack_err and halts.
  - A RET while it is invalid sets stack_err and halts.
  - RSTACK_DEPTH is ignored.

## Test plan
- Reset, start=1 with a memory word at address 1 (R-type) and instr_ready=1 -> instr_addr 1, then 2; instr_valid=1 in both cycles.
- instr_ready held 0 for 3 cycles on a datapath word at addr 5 -> instr_addr stays 5, instr_valid=1 for all 3 cycles; PC=6 one cycle after ready=1.
- BRANCH Z, offset 8'h06 at addr 4: flag_z=1 -> PC=11. flag_z=0 -> PC=5. Offset 8'hFA at addr 4 with flag_z=1 -> PC=12'hFFF (backward wrap).
- JSB to 45 at addr 40, then RET at addr 45 -> PC sequence 40, 45, 41; instr_valid=0 on both control cycles.
- With FETCH_RSTACK_EN defined: RSTACK_DEPTH+1 nested JSBs -> stack_err=1, halted=1. Without it, the second nested JSB does the same. RET on an empty stack -> stack_err=1.
- HALT word (19'h00000) at addr 11 -> halted=1 and PC stays 11. Then start=1 -> PC=START_ADDR, stack_err=0, and running resumes.
